alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute stage directly downstream of the ALU control decoder. It consumes the 4-bit alucontrol code together with two operands and produces a registered result and a zero flag; the zero flag feeds beq resolution.
- Logic and arithmetic operations complete in one cycle. Shifts run iteratively, one bit per cycle, which keeps the shifter small.
- Valid/ready handshakes sit on both the input side and the output side, so the stage can stall a multi-cycle datapath.

Parameters:
- XLEN, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and alucontrol are valid this cycle.
- in_ready  output  1  stage can accept an operation.
- alucontrol  input  4  operation code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1xxx reserved.
- srca  input  XLEN  operand A.
- srcb  input  XLEN  operand B; bits [SHAMT_W-1:0] give the shift amount for shift ops.
- flush  input  1  synchronous abort of the operation in flight.
- out_valid  output  1  result and zero are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  registered result.
- zero  output  1  registered; 1 when result == 0.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset: asynchronous on rst_n low.
  - state = IDLE; result = 0; zero = 1; out_valid = 0; busy = 0; internal shift count = 0.
  - Reset asserted mid-operation discards that operation, with no output produced.
- States and their outputs:
  - IDLE: in_ready = 1.
  - SHIFT: busy = 1, in_ready = 0.
  - DONE: out_valid = 1, in_ready = 0.
- Accept rule: an operation is accepted when in_valid and in_ready are both high on a rising edge of clk. Inputs are sampled only at accept and may change freely afterwards.
- Non-shift ops (0000–0100), on accept:
  - The result is registered and the state moves to DONE.
  - out_valid rises on the cycle after accept, so latency is 1 cycle.
  - add and sub wrap modulo 2^XLEN and carry/overflow are not reported; and, or and xor are bitwise.
- Reserved codes (1xxx) are executed as add; no error is flagged.
- Shift ops (0101–0111), on accept:
  - The accumulator is loaded with srca and the count with srcb[SHAMT_W-1:0].
  - If count == 0, the state goes straight to DONE and result = srca (latency 1).
  - Otherwise the state goes to SHIFT. Each cycle in SHIFT the accumulator shifts by 1 and the count decrements:
    - sll: left shift, zero fill.
    - srl: right shift, zero fill.
    - sra: right shift, replicating the MSB.
  - When the count reaches 0, the state goes to DONE. Latency is 1 + shamt cycles, so the maximum is 1 + (XLEN-1) = 32 cycles.
- zero is computed from the final result and updated on the same edge as result.
- DONE:
  - result and zero are held stable while out_valid = 1 and out_ready = 0; back-pressure is unbounded.
  - When out_valid and out_ready are both high, the state returns to IDLE and out_valid falls on the next cycle.
  - A new operation is not accepted in the same cycle as the output handshake; the minimum issue interval is 2 cycles.
- flush:
  - Sampled on the clock edge; applies from SHIFT or DONE and returns the state to IDLE on the next edge.
  - It clears out_valid and busy. result and zero keep their last values.
  - flush in IDLE cancels any simultaneous accept.
- Simultaneous events, in priority order: rst_n, then flush, then output handshake, then accept.
- Signals other than result and zero must not change while out_valid = 1.

Test Plan:
- Reset and sub zero flag: reset, then accept alucontrol=0001 with srca=srcb=32'h0000_0005 → one cycle later out_valid=1, result=0, zero=1. Then accept 0001 with srca=7, srcb=5 → result=2, zero=0.
- Logic ops, each in one cycle:
  - 0010 with srca=32'hF0F0_00FF, srcb=32'h0FF0_0F0F → result 32'h00F0_000F.
  - 0011 with the same operands → 32'hFFF0_0FFF.
  - 0100 with the same operands → 32'hFF00_0FF0.
  - Add wrap: 0000 with srca=32'hFFFF_FFFF, srcb=1 → result 0, zero=1.
- Shifts:
  - sra srca=32'h8000_0000, srcb=4 → busy for 4 cycles, out_valid on cycle 5, result 32'hF800_0000.
  - srl with the same operands → 32'h0800_0000.
  - sll srca=1, srcb=31 → 32'h8000_0000 after 32 cycles.
  - Any shift with shamt=0 → result=srca, latency 1.
- Back-pressure: hold out_ready=0 for 10 cycles after an add of 3+4 → result=7 stable and in_ready=0 throughout. Raise out_ready → out_valid drops next cycle and in_ready=1.
- Flush and reset mid-shift:
  - Start sll with shamt=20 and assert flush on cycle 5 → IDLE next cycle, out_valid never rises, in_ready=1.
  - Repeat the same shift, dropping rst_n asynchronously on cycle 8 → result=0, zero=1, state IDLE immediately.
- Reserved code: alucontrol=1010 with srca=2, srcb=3 → result 5, latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute stage behind the ALU control decoder: single-cycle logic/arithmetic,
// bit-serial shifts, valid/ready on both sides, registered result and zero flag.
module alu_exec_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alucontrol,
    input  logic [XLEN-1:0]    srca,
    input  logic [XLEN-1:0]    srcb,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic               zero,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t              r_state;
    logic [XLEN-1:0]     r_acc;
    logic [SHAMT_W-1:0]  r_cnt;
    logic [1:0]          r_op;
    logic [XLEN-1:0]     r_result;
    logic                r_zero;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [XLEN-1:0]     w_acc_nxt;
    logic [SHAMT_W-1:0]  w_cnt_nxt;
    logic [1:0]          w_op_nxt;
    logic [XLEN-1:0]     w_result_nxt;
    logic                w_zero_nxt;
    logic                w_is_shift;
    logic [XLEN-1:0]     w_alu_res;
    logic [XLEN-1:0]     w_acc_shifted;
    logic [SHAMT_W-1:0]  w_shamt;

    // Single-cycle datapath; reserved codes (1xxx) fall through to add.
    always_comb begin
        w_alu_res = srca + srcb;
        case (alucontrol)
            4'b0001: w_alu_res = srca - srcb;
            4'b0010: w_alu_res = srca & srcb;
            4'b0011: w_alu_res = srca | srcb;
            4'b0100: w_alu_res = srca ^ srcb;
            default: w_alu_res = srca + srcb;
        endcase
    end

    assign w_is_shift = (alucontrol == 4'b0101) || (alucontrol == 4'b0110) ||
                        (alucontrol == 4'b0111);
    assign w_shamt    = srcb[SHAMT_W-1:0];

    // One-bit shift step; r_op holds alucontrol[1:0] (01 sll, 10 srl, 11 sra).
    always_comb begin
        w_acc_shifted = r_acc;
        case (r_op)
            2'b01:   w_acc_shifted = {r_acc[XLEN-2:0], 1'b0};
            2'b10:   w_acc_shifted = {1'b0, r_acc[XLEN-1:1]};
            2'b11:   w_acc_shifted = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
            default: w_acc_shifted = r_acc;
        endcase
    end

    // Next state: flush beats the output handshake, which beats accept.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_result_nxt = r_result;
        w_zero_nxt   = r_zero;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_is_shift) begin
                            w_acc_nxt = srca;
                            w_cnt_nxt = w_shamt;
                            w_op_nxt  = alucontrol[1:0];
                            if (w_shamt == '0) begin
                                w_result_nxt = srca;
                                w_zero_nxt   = (srca == '0);
                                w_state_nxt  = DONE;
                            end else begin
                                w_state_nxt  = SHIFT;
                            end
                        end else begin
                            w_result_nxt = w_alu_res;
                            w_zero_nxt   = (w_alu_res == '0);
                            w_state_nxt  = DONE;
                        end
                    end
                end
                SHIFT: begin
                    w_acc_nxt = w_acc_shifted;
                    w_cnt_nxt = r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        w_result_nxt = w_acc_shifted;
                        w_zero_nxt   = (w_acc_shifted == '0);
                        w_state_nxt  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State, datapath and registered status outputs decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_result    <= w_result_nxt;
            r_zero      <= w_zero_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt == SHIFT);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, corner-case
// sequences and randomized operations against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int vectors;
    int miscompares;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return 32'($signed(a) >>> sh);
            default: return a + b;
        endcase
    endfunction

    function automatic bit is_shift_op(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd6) || (op == 4'd7);
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        return is_shift_op(op) ? 1 + int'(b[4:0]) : 1;
    endfunction

    // Present one operation at a negedge; accepted on the following posedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        alucontrol = op;
        srca       = a;
        srcb       = b;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        alucontrol = 4'($urandom);
        srca       = $urandom;
        srcb       = $urandom;
    endtask

    // Count negedges after the accept edge until out_valid, bounded.
    task automatic wait_done(input bit shifting, output int lat);
        bit bad;
        lat = 0;
        bad = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (busy !== shifting || in_ready !== 1'b0) bad = 1'b1;
        end
        chk("out_valid_within_bound", 32'(out_valid), 32'd1);
        chk("busy_in_ready_while_pending", 32'(bad), 32'd0);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
        chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          lat;
        bit          bad;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        alucontrol  = '0;
        srca        = '0;
        srcb        = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        vecs[0]  = '{4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1};
        vecs[1]  = '{4'b0001, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b0, 1};
        vecs[2]  = '{4'b0010, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1};
        vecs[3]  = '{4'b0011, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1};
        vecs[4]  = '{4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0, 1};
        vecs[5]  = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};
        vecs[6]  = '{4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 5};
        vecs[7]  = '{4'b0110, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 5};
        vecs[8]  = '{4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32};
        vecs[9]  = '{4'b0110, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 1};
        vecs[10] = '{4'b0101, 32'h0000_0000, 32'hFFFF_FFE0, 32'h0000_0000, 1'b1, 1};
        vecs[11] = '{4'b1010, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1};
        vecs[12] = '{4'b0101, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 32};

        repeat (3) @(negedge clk);
        chk("reset_result", result, 32'd0);
        chk("reset_zero", 32'(zero), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed vector table.
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].lat > 1, lat);
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            handshake();
        end

        // Flush in IDLE cancels a simultaneous accept.
        @(negedge clk);
        in_valid   = 1'b1;
        alucontrol = 4'b0000;
        srca       = 32'd9;
        srcb       = 32'd9;
        flush      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("idle_flush_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        chk("idle_flush_no_output", 32'(out_valid), 32'd0);

        // Back-pressure: add 3+4 held for 10 cycles.
        issue(4'b0000, 32'd3, 32'd4);
        wait_done(1'b0, lat);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (result !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0)
                bad = 1'b1;
        end
        chk("backpressure_hold", 32'(bad), 32'd0);
        handshake();

        // Flush mid-shift: sll shamt 20, flush sampled on cycle 5.
        issue(4'b0101, 32'h0000_0001, 32'd20);
        repeat (4) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_result_kept", result, 32'd7);
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        chk("flush_no_output", 32'(bad), 32'd0);

        // Randomized operations with random back-pressure.
        for (int n = 0; n < 40; n++) begin
            op    = 4'($urandom_range(0, 15));
            a     = $urandom;
            b     = $urandom;
            if (n % 8 == 0) a = 32'd0;
            if (n % 5 == 0) b = a;
            exp_r = model_res(op, a, b);
            issue(op, a, b);
            wait_done(model_lat(op, b) > 1, lat);
            chk("rand_result", result, exp_r);
            chk("rand_zero", 32'(zero), 32'(exp_r == 32'd0));
            chk("rand_latency", 32'(lat), 32'(model_lat(op, b)));
            bad = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                if (result !== exp_r || out_valid !== 1'b1) bad = 1'b1;
            end
            chk("rand_hold", 32'(bad), 32'd0);
            handshake();
        end

        // Asynchronous reset mid-shift on cycle 8.
        issue(4'b0101, 32'h0000_0001, 32'd20);
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_result", result, 32'd0);
        chk("async_rst_zero", 32'(zero), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery after reset.
        issue(4'b1111, 32'd2, 32'd3);
        wait_done(1'b0, lat);
        chk("post_reset_result", result, 32'd5);
        chk("post_reset_latency", 32'(lat), 32'd1);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
